mask_centroid: RTL and testbench

Downstream stage of the RGB→YCbCr / skin-binarization path. It consumes the binarized video stream (`{bin,bin,bin}`, where bin is 0 or 255), accumulates the zeroth- and first-order image moments of the mask over each frame, and divides them at frame end to get the mask centroid. It re-emits the video with a 1-cycle delay. When the centroid is valid, a red crosshair is overlaid at the centroid position.

---
 rtl/vp_pkg.sv | 12 +
 rtl/seq_div.sv | 56 +++++
 rtl/mask_centroid.sv | 155 +++++++++++++++
 tb/tb_mask_centroid.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// Shared constants and types for the video-processing path (binarize -> centroid).
package vp_pkg;
    localparam int          DEF_H_ACTIVE   = 1280;
    localparam int          DEF_V_ACTIVE   = 720;
    localparam int          X_W            = 11;
    localparam int          Y_W            = 10;
    localparam int          DEF_ACC_W      = 32;
    localparam int          DEF_CNT_W      = 20;
    localparam logic [23:0] DEF_MARK_COLOR = 24'hFF0000;

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/seq_div.sv
// Restoring unsigned divider: one quotient bit per cycle, DIVIDEND_W cycles per result.
module seq_div #(
    parameter int DIVIDEND_W = 32,
    parameter int DIVISOR_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);
    localparam int CW = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0] rem;
    logic [DIVISOR_W-1:0] dsr;
    logic [CW-1:0]        cnt;
    logic [DIVISOR_W:0]   rem_sh;
    logic [DIVISOR_W-1:0] diff;
    logic                 ge;

    // The dividend shifts out of the quotient register as quotient bits shift in.
    assign rem_sh = {rem, quotient[DIVIDEND_W-1]};
    assign ge     = rem_sh >= {1'b0, dsr};
    assign diff   = rem_sh[DIVISOR_W-1:0] - dsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            quotient <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                rem      <= '0;
                dsr      <= divisor;
                quotient <= dividend;
                cnt      <= CW'(DIVIDEND_W);
                busy     <= 1'b1;
            end else if (busy) begin
                quotient <= {quotient[DIVIDEND_W-2:0], ge};
                rem      <= ge ? diff : rem_sh[DIVISOR_W-1:0];
                cnt      <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mask_centroid.sv
// Accumulates mask moments per frame, divides at frame end to get the centroid,
// and re-emits the video one cycle late with a crosshair at the last valid centroid.
module mask_centroid
    import vp_pkg::*;
#(
    parameter int          H_ACTIVE   = DEF_H_ACTIVE,
    parameter int          V_ACTIVE   = DEF_V_ACTIVE,
    parameter int          ACC_W      = DEF_ACC_W,
    parameter int          CNT_W      = DEF_CNT_W,
    parameter logic [23:0] MARK_COLOR = DEF_MARK_COLOR
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           de_in,
    input  logic           h_sync_in,
    input  logic           v_sync_in,
    input  logic [23:0]    pixel_in,
    output logic [23:0]    pixel_out,
    output logic           h_sync_out,
    output logic           v_sync_out,
    output logic           de_out,
    output logic [X_W-1:0] centroid_x,
    output logic [Y_W-1:0] centroid_y,
    output logic           centroid_valid,
    output logic           overrun
);
    state_t           state;
    logic             vs_q, de_q;
    logic             frame_end, de_fall, mark_hit;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [CNT_W-1:0] m00, snap_m00;
    logic [ACC_W-1:0] m10, m01, snap_m10, snap_m01;
    logic             start_q;
    logic [ACC_W-1:0] quo_x, quo_y;
    logic             busy_x, busy_y, done_x, done_y;
    logic             unused_bits;

    assign frame_end = v_sync_in & ~vs_q;
    assign de_fall   = ~de_in & de_q;
    assign mark_hit  = centroid_valid & de_in & ((x == centroid_x) | (y == centroid_y));

    // Counters stop at the active size so malformed timing cannot wrap them.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= 1'b0;
            de_q <= 1'b0;
            x    <= '0;
            y    <= '0;
            m00  <= '0;
            m10  <= '0;
            m01  <= '0;
        end else begin
            vs_q <= v_sync_in;
            de_q <= de_in;
            if (de_in) begin
                if (x != X_W'(H_ACTIVE)) x <= x + X_W'(1);
            end else if (de_q) begin
                x <= '0;
            end
            if (frame_end)
                y <= '0;
            else if (de_fall && y != Y_W'(V_ACTIVE))
                y <= y + Y_W'(1);
            if (frame_end) begin
                m00 <= '0;
                m10 <= '0;
                m01 <= '0;
            end else if (de_in && pixel_in[23]) begin
                m00 <= m00 + CNT_W'(1);
                m10 <= m10 + ACC_W'(x);
                m01 <= m01 + ACC_W'(y);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_out  <= '0;
            de_out     <= 1'b0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
        end else begin
            pixel_out  <= mark_hit ? MARK_COLOR : pixel_in;
            de_out     <= de_in;
            h_sync_out <= h_sync_in;
            v_sync_out <= v_sync_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            start_q        <= 1'b0;
            snap_m00       <= '0;
            snap_m10       <= '0;
            snap_m01       <= '0;
            centroid_x     <= '0;
            centroid_y     <= '0;
            centroid_valid <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (frame_end && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (frame_end) begin
                        // An empty mask has no centroid; keep the old position, drop valid.
                        if (m00 == '0) begin
                            centroid_valid <= 1'b0;
                        end else begin
                            snap_m00 <= m00;
                            snap_m10 <= m10;
                            snap_m01 <= m01;
                            start_q  <= 1'b1;
                            state    <= DIV;
                        end
                    end
                end
                DIV: if (done_x && done_y) state <= DONE;
                DONE: begin
                    centroid_x     <= quo_x[X_W-1:0];
                    centroid_y     <= quo_y[Y_W-1:0];
                    centroid_valid <= 1'b1;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    seq_div #(.DIVIDEND_W(ACC_W), .DIVISOR_W(CNT_W)) u_div_x (
        .clk      (clk),
        .rst      (rst),
        .start    (start_q),
        .dividend (snap_m10),
        .divisor  (snap_m00),
        .busy     (busy_x),
        .done     (done_x),
        .quotient (quo_x)
    );

    seq_div #(.DIVIDEND_W(ACC_W), .DIVISOR_W(CNT_W)) u_div_y (
        .clk      (clk),
        .rst      (rst),
        .start    (start_q),
        .dividend (snap_m01),
        .divisor  (snap_m00),
        .busy     (busy_y),
        .done     (done_y),
        .quotient (quo_y)
    );

    assign unused_bits = ^{quo_x[ACC_W-1:X_W], quo_y[ACC_W-1:Y_W], busy_x, busy_y};
endmodule

// File: tb/tb_mask_centroid.sv
// Directed bench for mask_centroid on a 64-pixel-wide raster with short frames.
module tb_mask_centroid;
    localparam int          H    = 64;
    localparam logic [23:0] MARK = 24'hFF0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
    logic [23:0] pixel_in = 24'h0;
    logic [23:0] pixel_out;
    logic        h_sync_out, v_sync_out, de_out;
    logic [10:0] centroid_x;
    logic [9:0]  centroid_y;
    logic        centroid_valid, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    mask_centroid #(
        .H_ACTIVE(64), .V_ACTIVE(48), .ACC_W(32), .CNT_W(20), .MARK_COLOR(MARK)
    ) dut (
        .clk(clk), .rst(rst), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .pixel_in(pixel_in), .pixel_out(pixel_out), .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out), .de_out(de_out), .centroid_x(centroid_x),
        .centroid_y(centroid_y), .centroid_valid(centroid_valid), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after an edge; outputs are read at the same point.
    task automatic drive(input logic de, input logic hs, input logic vs, input logic [23:0] pix);
        de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic vsync_pulse;
        repeat (4) drive(1'b0, 1'b0, 1'b1, 24'h0);
    endtask

    function automatic logic in_mask(input int mode, input int x, input int y);
        case (mode)
            1:       return (x == 10 && y == 5);
            2:       return (x >= 20 && x <= 23 && y >= 8 && y <= 11);
            3:       return (x == 0 && y == 0) || (x == 63 && y == 7);
            default: return 1'b0;
        endcase
    endfunction

    task automatic send_frame(input int mode, input int lines);
        for (int ly = 0; ly < lines; ly++) begin
            for (int lx = 0; lx < H; lx++)
                drive(1'b1, 1'b0, 1'b0, in_mask(mode, lx, ly) ? 24'hFFFFFF : 24'h0);
            for (int b = 0; b < 4; b++)
                drive(1'b0, (b == 1 || b == 2), 1'b0, 24'h0);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        drive(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        n_cmp++;
        if ({pixel_out, de_out, h_sync_out, v_sync_out} !== 27'h0) begin
            n_bad++;
            $display("FAIL reset_video: got pix=%h de=%b hs=%b vs=%b want all 0", pixel_out, de_out, h_sync_out, v_sync_out);
        end
        n_cmp++;
        if ({centroid_x, centroid_y, centroid_valid, overrun} !== 23'h0) begin
            n_bad++;
            $display("FAIL reset_centroid: got x=%0d y=%0d v=%b ovr=%b want all 0", centroid_x, centroid_y, centroid_valid, overrun);
        end
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single_pixel;
        send_frame(1, 8);
        vsync_pulse();
        idle(31);
        n_cmp++;
        if (centroid_valid !== 1'b0 || centroid_x !== 11'd0) begin
            n_bad++;
            $display("FAIL single_early: got v=%b x=%0d at cycle 34, want v=0 x=0", centroid_valid, centroid_x);
        end
        idle(1);
        n_cmp++;
        if (centroid_valid !== 1'b1) begin
            n_bad++; $display("FAIL single_valid: got %b want 1", centroid_valid);
        end
        n_cmp++;
        if (centroid_x !== 11'd10) begin
            n_bad++; $display("FAIL single_x: got %0d want 10", centroid_x);
        end
        n_cmp++;
        if (centroid_y !== 10'd5) begin
            n_bad++; $display("FAIL single_y: got %0d want 5", centroid_y);
        end
    endtask

    task automatic test_rect;
        send_frame(2, 12);
        vsync_pulse();
        idle(40);
        n_cmp++;
        if (centroid_valid !== 1'b1 || centroid_x !== 11'd21 || centroid_y !== 10'd9 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL rect: got x=%0d y=%0d v=%b ovr=%b want x=21 y=9 v=1 ovr=0", centroid_x, centroid_y, centroid_valid, overrun);
        end
    endtask

    task automatic test_overlay;
        logic [23:0] exp_pix;
        logic        hs;
        for (int ly = 0; ly < 12; ly++) begin
            for (int lx = 0; lx < H; lx++) begin
                drive(1'b1, 1'b0, 1'b0, 24'h0);
                exp_pix = (lx == 21 || ly == 9) ? MARK : 24'h0;
                n_cmp++;
                if (pixel_out !== exp_pix || de_out !== 1'b1 || h_sync_out !== 1'b0 || v_sync_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL overlay (%0d,%0d): got pix=%h de=%b hs=%b vs=%b want pix=%h de=1 hs=0 vs=0",
                             lx, ly, pixel_out, de_out, h_sync_out, v_sync_out, exp_pix);
                end
            end
            for (int b = 0; b < 4; b++) begin
                hs = (b == 1 || b == 2);
                drive(1'b0, hs, 1'b0, 24'h0);
                n_cmp++;
                if (pixel_out !== 24'h0 || de_out !== 1'b0 || h_sync_out !== hs) begin
                    n_bad++;
                    $display("FAIL blank line %0d: got pix=%h de=%b hs=%b want pix=0 de=0 hs=%b", ly, pixel_out, de_out, h_sync_out, hs);
                end
            end
        end
        drive(1'b0, 1'b0, 1'b1, 24'h0);
        n_cmp++;
        if (v_sync_out !== 1'b1 || pixel_out !== 24'h0) begin
            n_bad++; $display("FAIL vsync_pass: got vs=%b pix=%h want vs=1 pix=0", v_sync_out, pixel_out);
        end
        repeat (3) drive(1'b0, 1'b0, 1'b1, 24'h0);
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        n_cmp++;
        if (v_sync_out !== 1'b0) begin
            n_bad++; $display("FAIL vsync_fall: got %b want 0", v_sync_out);
        end
    endtask

    task automatic test_empty;
        idle(40);
        n_cmp++;
        if (centroid_valid !== 1'b0) begin
            n_bad++; $display("FAIL empty_valid: got %b want 0", centroid_valid);
        end
        n_cmp++;
        if (centroid_x !== 11'd21 || centroid_y !== 10'd9) begin
            n_bad++; $display("FAIL empty_hold: got x=%0d y=%0d want x=21 y=9", centroid_x, centroid_y);
        end
    endtask

    task automatic test_corners;
        send_frame(3, 8);
        vsync_pulse();
        idle(40);
        n_cmp++;
        if (centroid_valid !== 1'b1 || centroid_x !== 11'd31 || centroid_y !== 10'd3) begin
            n_bad++;
            $display("FAIL corners: got x=%0d y=%0d v=%b want x=31 y=3 v=1", centroid_x, centroid_y, centroid_valid);
        end
    endtask

    task automatic test_reset_mid_div;
        send_frame(2, 12);
        vsync_pulse();
        idle(6);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 24'h0);
        rst = 1'b0;
        n_cmp++;
        if ({pixel_out, de_out, h_sync_out, v_sync_out, centroid_x, centroid_y, centroid_valid, overrun} !== 50'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got pix=%h x=%0d y=%0d v=%b ovr=%b want all 0", pixel_out, centroid_x, centroid_y, centroid_valid, overrun);
        end
        idle(30);
        n_cmp++;
        if (centroid_valid !== 1'b0 || centroid_x !== 11'd0 || centroid_y !== 10'd0) begin
            n_bad++;
            $display("FAIL aborted_div: got x=%0d y=%0d v=%b want x=0 y=0 v=0", centroid_x, centroid_y, centroid_valid);
        end
        send_frame(2, 12);
        vsync_pulse();
        idle(40);
        n_cmp++;
        if (centroid_valid !== 1'b1 || centroid_x !== 11'd21 || centroid_y !== 10'd9) begin
            n_bad++;
            $display("FAIL after_reset: got x=%0d y=%0d v=%b want x=21 y=9 v=1", centroid_x, centroid_y, centroid_valid);
        end
    endtask

    task automatic test_overrun;
        send_frame(1, 8);
        drive(1'b0, 1'b0, 1'b1, 24'h0);
        idle(4);
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++; $display("FAIL overrun_early: got %b want 0", overrun);
        end
        drive(1'b0, 1'b0, 1'b1, 24'h0);
        n_cmp++;
        if (overrun !== 1'b1) begin
            n_bad++; $display("FAIL overrun_set: got %b want 1", overrun);
        end
        repeat (2) drive(1'b0, 1'b0, 1'b1, 24'h0);
        idle(27);
        n_cmp++;
        if (centroid_x !== 11'd21 || centroid_valid !== 1'b1) begin
            n_bad++; $display("FAIL overrun_hold: got x=%0d v=%b at cycle 34, want x=21 v=1", centroid_x, centroid_valid);
        end
        idle(1);
        n_cmp++;
        if (centroid_valid !== 1'b1 || centroid_x !== 11'd10 || centroid_y !== 10'd5 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_result: got x=%0d y=%0d v=%b ovr=%b want x=10 y=5 v=1 ovr=1", centroid_x, centroid_y, centroid_valid, overrun);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_rect();
        test_overlay();
        test_empty();
        test_corners();
        test_reset_mid_div();
        test_overrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
